// File: rtl/add_arbiter_pkg.sv
// add_arbiter_pkg -- shared definitions for the add_arbiter block.
//   state_t  : result-slot FSM encoding (EMPTY = no result held, FULL = result held)
//   NREQ_DEF : default number of requesters
//   W_DEF    : default operand/result width
package add_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 32;

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// rr_pick -- round-robin search for the shared adder.
// Returns a one-hot grant for the first asserted request at or after rr_ptr,
// searching upward and wrapping from NREQ-1 back to 0. All-zero if req is zero.
// Ports:
//   req    in  NREQ  request vector
//   rr_ptr in  PW    search start index
//   gnt    out NREQ  one-hot grant
module rr_pick
  import add_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt
);

  logic found;
  int   idx;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter -- NREQ requesters share one W-bit adder through a round-robin
// arbiter; the sum is held in a single result register with valid/ready output.
// Optional feature: define ADD_ARBITER_OVF_EN to add res_ovf (signed overflow).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req   [NREQ]       per-requester request, operands valid while high
//   op_a  [NREQ*W]     packed operand A, requester i at [i*W +: W]
//   op_b  [NREQ*W]     packed operand B, same packing
//   gnt   [NREQ]       combinational one-hot grant; accept = req & gnt
//   res_valid          result register holds a valid sum
//   res_ready          consumer accepts result when res_valid & res_ready
//   res_data [W]       registered sum modulo 2^W
//   res_carry          unsigned carry-out of the sum
//   res_ovf            (ADD_ARBITER_OVF_EN only) signed overflow of the sum
//   res_id  [clog2]    requester index that produced res_data
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0] gnt,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_data,
  output logic            res_carry,
`ifdef ADD_ARBITER_OVF_EN
  output logic            res_ovf,
`endif
  output logic [IW-1:0]   res_id
);

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr;
  logic [NREQ-1:0] pick;
  logic            slot_free;
  logic            accept;
  logic [IW-1:0]   gnt_idx;
  logic [W-1:0]    sel_a, sel_b;
  logic [W:0]      sum;

  rr_pick #(.NREQ(NREQ), .PW(IW)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (pick)
  );

  // The slot can take a new sum when empty or when the held one leaves this
  // cycle. rst_n gates the grant so nothing is offered while reset is held.
  assign slot_free = (state_q == EMPTY) | res_ready;
  assign gnt       = (slot_free && rst_n) ? pick : '0;
  assign accept    = |(req & gnt);
  assign res_valid = (state_q == FULL);

  // One-hot grant to index, and AND-OR operand mux feeding the single adder.
  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = IW'(i);
      sel_a = sel_a | (op_a[i*W +: W] & {W{gnt[i]}});
      sel_b = sel_b | (op_b[i*W +: W] & {W{gnt[i]}});
    end
  end

  assign sum = {1'b0, sel_a} + {1'b0, sel_b};

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (res_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  // NOTE: the result register is reset too, because res_data/res_carry/res_id
  // are observable and must read 0 out of reset, not just be qualified by
  // res_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
    end else if (accept) begin
      res_data  <= sum[W-1:0];
      res_carry <= sum[W];
      res_id    <= gnt_idx;
    end
  end

`ifdef ADD_ARBITER_OVF_EN
  // Signed overflow: operands share a sign and the sum's sign differs.
  logic ovf_d;
  assign ovf_d = (sel_a[W-1] == sel_b[W-1]) && (sum[W-1] != sel_a[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      res_ovf <= 1'b0;
    else if (accept) res_ovf <= ovf_d;
  end
`endif

endmodule
